ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch and PC-sequencing stage for the MIPS core. It feeds the control decoder and consumes its results. The unit holds the PC, fetches each instruction over a req/ack instruction-memory port, and presents the op/func fields plus the full instruction to the control decoder. It then computes the next PC from the decoder's branch and jump outputs. A sticky error flag is raised if memory never acknowledges a fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max FETCH cycles waiting for imem_ack before error (minimum 1)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  instruction word, valid when imem_ack=1
imem_ack  in  1  memory accept/data-valid strobe
instr  out  32  registered current instruction
op  out  6  instr[31:26], to control decoder
func  out  6  instr[5:0], to control decoder
instr_valid  out  1  instr is held for execution
stall  in  1  hold current instruction (core not ready to retire)
brnch  in  1  branch-taken from control decoder (already ANDed with zero)
jmp  in  1  jump from control decoder
pc  out  32  current PC
pc_plus4  out  32  pc + 4
retire_cnt  out  32  instructions retired
fetch_err  out  1  sticky fetch-timeout flag

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n); all state is clocked on the rising edge of clk.
- Reset values (applied immediately on rst_n=0):
  - state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, retire_cnt=0, fetch_err=0, wait counter=0.
- FSM states: IDLE, FETCH, EXEC, ERR.
- IDLE:
  - First edge after rst_n deasserts -> FETCH.
  - No outputs asserted.
- FETCH:
  - imem_req=1 combinationally from state; imem_addr=pc, held stable until ack.
  - Edge with imem_ack=1: instr<=imem_rdata, wait counter<=0, -> EXEC.
  - Edge with imem_ack=0: wait counter++.
  - When the counter reaches TIMEOUT-1 and ack is still 0 on that edge: -> ERR, fetch_err<=1.
- EXEC:
  - instr_valid=1, imem_req=0.
  - stall=1: remain; instr, pc and retire_cnt are unchanged.
  - stall=0 at edge: pc<=next_pc, retire_cnt<=retire_cnt+1 (wraps at 2^32), -> FETCH.
  - Minimum latency per instruction is 2 cycles (ack in the first FETCH cycle, no stall).
- ERR:
  - imem_req=0, instr_valid=0, fetch_err=1.
  - Remains until reset.
- next_pc (combinational, mod 2^32):
  - jmp=1: {pc_plus4[31:28], instr[25:0], 2'b00}. jmp has priority; brnch is ignored (the decoder drives brnch=X for J).
  - else brnch=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else: pc_plus4.
- brnch/jmp are sampled only on the EXEC retiring edge and ignored in all other states.
- imem_ack outside FETCH is ignored. imem_rdata is captured only when ack=1 in FETCH.
- Reset mid-fetch or mid-EXEC aborts immediately: imem_req falls asynchronously and pc returns to RESET_PC.
- Undefined opcodes produce X from the decoder. Such opcodes are outside the contract, and the bench must not issue them.
- Arithmetic: all PC math is 32-bit unsigned with silent wrap (e.g. 32'hFFFF_FFFC + 4 = 0).

Test Plan:
- Reset, then ack on the first FETCH cycle with rdata=32'h2008_0005 (addi), brnch=0, jmp=0 -> imem_addr=0, instr captured, instr_valid for 1 cycle, pc becomes 4, retire_cnt=1.
- Fetch at pc=8 of BEQ with imm=16'hFFFE and brnch=1 -> next pc = 12 + (-8) = 4. Repeat with brnch=0 -> pc=12.
- J instr=32'h0800_0010 at pc=32'h1000_0000, jmp=1, brnch=X -> pc=32'h1000_0040.
- Ack delayed 3 cycles with TIMEOUT=16 -> imem_req and imem_addr stable for 4 cycles, no error. Hold ack low for 16 cycles -> ERR, fetch_err=1, req=0, and no recovery until rst_n pulse.
- stall=1 for 5 cycles in EXEC -> instr, pc and retire_cnt frozen. Then stall=0 -> single retire.
- Assert rst_n=0 mid-FETCH between clock edges -> imem_req drops without a clock edge, pc=RESET_PC. pc=32'hFFFF_FFFC sequential retire -> pc wraps to 0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch and PC-sequencing stage.
//
// Holds the PC and fetches one instruction at a time over a req/ack memory port.
// The fetched word is presented to the control decoder as op/func plus the full
// word. When the instruction retires, the PC advances using the decoder's
// brnch/jmp results. A sticky error is raised if a fetch is never acknowledged.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (address is the PC)
//   imem_rdata/imem_ack instruction word and accept/data-valid strobe
//   instr, op, func     registered instruction and its decoder fields
//   instr_valid         instr is held for execution
//   stall               hold the current instruction (core not ready to retire)
//   brnch, jmp          branch-taken / jump from the control decoder
//   pc, pc_plus4        current PC and PC + 4
//   retire_cnt          number of retired instructions (wraps)
//   fetch_err           sticky fetch-timeout flag
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        brnch,
    input  logic        jmp,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_cnt,
    output logic        fetch_err
);

    // Counter must be at least one bit wide even when TIMEOUT is 1.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        Idle,
        Fetch,
        Exec,
        Err
    } stateT;

    stateT           state;
    logic [CntW-1:0] waitCnt;
    logic [31:0]     nextPc;
    logic [31:0]     branchOff;

    // Request and valid decode straight from state so an asynchronous reset
    // drops them without waiting for a clock edge.
    assign imem_req    = (state == Fetch);
    assign instr_valid = (state == Exec);
    assign imem_addr   = pc;
    assign pc_plus4    = pc + 32'd4;
    assign op          = instr[31:26];
    assign func        = instr[5:0];

    // jmp wins over brnch; the decoder leaves brnch undefined for J.
    always_comb begin
        branchOff = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (jmp) begin
            nextPc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (brnch) begin
            nextPc = pc_plus4 + branchOff;
        end else begin
            nextPc = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= Idle;
            pc         <= RESET_PC;
            instr      <= 32'h0;
            retire_cnt <= 32'h0;
            fetch_err  <= 1'b0;
            waitCnt    <= '0;
        end else begin
            unique case (state)
                Idle: begin
                    state <= Fetch;
                end
                Fetch: begin
                    if (imem_ack) begin
                        instr   <= imem_rdata;
                        waitCnt <= '0;
                        state   <= Exec;
                    end else if (waitCnt == CntMax) begin
                        // TIMEOUT cycles without an ack: give up for good.
                        fetch_err <= 1'b1;
                        state     <= Err;
                    end else begin
                        waitCnt <= waitCnt + CntW'(1);
                    end
                end
                Exec: begin
                    if (!stall) begin
                        pc         <= nextPc;
                        retire_cnt <= retire_cnt + 32'd1;
                        state      <= Fetch;
                    end
                end
                Err: begin
                    // Only reset leaves this state.
                    fetch_err <= 1'b1;
                end
                default: begin
                    state <= Idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a scoreboard of expected fetches
// (address, word, next PC) checked as each instruction executes and retires.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        instr_valid;
    logic        stall;
    logic        brnch;
    logic        jmp;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retire_cnt;
    logic        fetch_err;

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .instr_valid (instr_valid),
        .stall       (stall),
        .brnch       (brnch),
        .jmp         (jmp),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire_cnt  (retire_cnt),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] nextPc;
    } expT;

    expT         sb[$];
    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] modelPc;
    logic [31:0] modelRetire;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] nextPcOf(input logic [31:0] p, input logic [31:0] w,
                                             input logic b, input logic j);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (j) return {p4[31:28], w[25:0], 2'b00};
        if (b) return p4 + {{14{w[15]}}, w[15:0], 2'b00};
        return p4;
    endfunction

    function automatic logic [31:0] addiWord();
        logic [31:0] r;
        r = $urandom;
        return 32'h2008_0000 | {16'h0, r[15:0]};
    endfunction

    // Called at a negedge with the DUT in FETCH; returns at a negedge in FETCH.
    task automatic runInstr(input logic [31:0] word, input int delay, input logic b,
                            input logic j, input int stallCycles);
        expT e;
        int  waitN;
        waitN = 0;
        while (!imem_req && waitN < 8) begin
            @(negedge clk);
            waitN++;
        end
        checkVal("req_seen", imem_req, 1);
        if (!imem_req) return;
        for (int i = 0; i < delay; i++) begin
            checkVal("req_hold", imem_req, 1);
            checkVal("addr_hold", imem_addr, modelPc);
            imem_ack = 1'b0;
            @(negedge clk);
        end
        checkVal("addr", imem_addr, modelPc);
        e.addr   = modelPc;
        e.word   = word;
        e.nextPc = nextPcOf(modelPc, word, b, j);
        sb.push_back(e);
        imem_ack   = 1'b1;
        imem_rdata = word;
        brnch      = b;
        jmp        = j;
        stall      = (stallCycles > 0);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (sb.size() == 0) begin
            checkVal("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        checkVal("valid", instr_valid, 1);
        checkVal("req_exec", imem_req, 0);
        checkVal("instr", instr, e.word);
        checkVal("op", op, e.word[31:26]);
        checkVal("func", func, e.word[5:0]);
        checkVal("pc_exec", pc, e.addr);
        checkVal("pc_plus4", pc_plus4, e.addr + 32'd4);
        if (stallCycles > 0) begin
            // Ack during EXEC must be ignored.
            imem_ack   = 1'b1;
            imem_rdata = ~word;
        end
        for (int s = 0; s < stallCycles; s++) begin
            @(negedge clk);
            checkVal("stall_instr", instr, e.word);
            checkVal("stall_pc", pc, e.addr);
            checkVal("stall_retire", retire_cnt, modelRetire);
            checkVal("stall_valid", instr_valid, 1);
            if (s == stallCycles - 1) begin
                stall    = 1'b0;
                imem_ack = 1'b0;
            end
        end
        @(negedge clk);
        modelPc     = e.nextPc;
        modelRetire = modelRetire + 32'd1;
        checkVal("pc_next", pc, modelPc);
        checkVal("retire", retire_cnt, modelRetire);
        checkVal("valid_drop", instr_valid, 0);
        checkVal("req_refetch", imem_req, 1);
        brnch = 1'b0;
        jmp   = 1'b0;
    endtask

    // Resets, checks reset values, releases; returns at a negedge in FETCH.
    task automatic doReset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        stall    = 1'b0;
        brnch    = 1'b0;
        jmp      = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("rst_pc", pc, 32'h0);
        checkVal("rst_instr", instr, 32'h0);
        checkVal("rst_req", imem_req, 0);
        checkVal("rst_valid", instr_valid, 0);
        checkVal("rst_retire", retire_cnt, 32'h0);
        checkVal("rst_err", fetch_err, 0);
        rst_n = 1'b1;
        #1;
        checkVal("idle_req", imem_req, 0);
        @(negedge clk);
        modelPc     = 32'h0;
        modelRetire = 32'h0;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        brnch      = 1'b0;
        jmp        = 1'b0;
        doReset();

        runInstr(32'h2008_0005, 0, 1'b0, 1'b0, 0);
        checkVal("addi_pc", pc, 32'h4);
        checkVal("addi_retire", retire_cnt, 32'h1);
        runInstr(addiWord(), 3, 1'b0, 1'b0, 0);
        runInstr(32'h1000_FFFE, 0, 1'b1, 1'b0, 0);
        checkVal("beq_taken", pc, 32'h4);
        runInstr(addiWord(), 1, 1'b0, 1'b0, 5);
        runInstr(32'h1000_FFFE, 0, 1'b0, 1'b0, 0);
        checkVal("beq_not_taken", pc, 32'hC);
        runInstr(32'h0BFF_FFFF, 0, 1'b0, 1'b1, 0);
        runInstr(addiWord(), 0, 1'b0, 1'b0, 0);
        checkVal("region_step", pc, 32'h1000_0000);
        runInstr(32'h0800_0010, 0, 1'($urandom_range(0, 1)), 1'b1, 0);
        checkVal("j_target", pc, 32'h1000_0040);

        // Walk up through every PC region to reach the top of the address space.
        for (int r = 1; r < 16; r++) begin
            runInstr(32'h0BFF_FFFF, 0, 1'($urandom_range(0, 1)), 1'b1, 0);
            runInstr(addiWord(), r % 3, 1'b0, 1'b0, 0);
        end
        checkVal("pc_wrap", pc, 32'h0);
        runInstr(addiWord(), 0, 1'b0, 1'b0, 0);

        // Asynchronous reset between edges while fetching from pc=4.
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_req", imem_req, 0);
        checkVal("async_pc", pc, 32'h0);
        checkVal("async_retire", retire_cnt, 32'h0);
        @(negedge clk);
        doReset();
        runInstr(addiWord(), 2, 1'b0, 1'b0, 0);

        // Fetch timeout: 16 cycles without ack.
        imem_ack = 1'b0;
        repeat (15) @(negedge clk);
        checkVal("to_req_before", imem_req, 1);
        checkVal("to_err_before", fetch_err, 0);
        @(negedge clk);
        checkVal("to_err", fetch_err, 1);
        checkVal("to_req", imem_req, 0);
        checkVal("to_valid", instr_valid, 0);
        imem_ack = 1'b1;
        repeat (4) @(negedge clk);
        checkVal("err_sticky", fetch_err, 1);
        checkVal("err_no_req", imem_req, 0);
        checkVal("err_pc", pc, modelPc);
        imem_ack = 1'b0;

        doReset();
        runInstr(32'h2008_0005, 0, 1'b0, 1'b0, 0);
        checkVal("recover_pc", pc, 32'h4);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
